// File: rtl/hc_283.sv
// hc_283: registered unsigned adder with a full carry-lookahead core (74x283 style).
// Sum and carry-out are captured one clock after the operands; reset clears them at once.
`default_nettype none

module hc_283 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  output logic             Cout,
  output logic [WIDTH-1:0] DataOut
);

  logic [WIDTH-1:0]              w_gen;
  logic [WIDTH-1:0]              w_prop;
  logic [WIDTH:0]                w_carry;
  logic [WIDTH-1:0]              w_sum;
  logic [WIDTH:1][WIDTH-1:0]     w_term;

  logic [WIDTH-1:0]              r_sum;
  logic                          r_cout;

  assign w_gen  = DataIn1 & DataIn2;
  assign w_prop = DataIn1 ^ DataIn2;

  // No carry-in port: the LSB carry is tied low, so every carry is a pure
  // sum of generate terms each qualified by the propagates above it.
  assign w_carry[0] = 1'b0;

  for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
    for (genvar j = 0; j < WIDTH; j++) begin : g_term
      if (j == i - 1) begin : g_direct
        assign w_term[i][j] = w_gen[j];
      end else if (j < i - 1) begin : g_chain
        assign w_term[i][j] = w_gen[j] & (&w_prop[i-1:j+1]);
      end else begin : g_none
        assign w_term[i][j] = 1'b0;
      end
    end
    assign w_carry[i] = |w_term[i];
  end

  assign w_sum = w_prop ^ w_carry[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_carry[WIDTH];
    end
  end

  assign DataOut = r_sum;
  assign Cout    = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_hc_283.sv
// tb_hc_283: directed and exhaustive self-checking bench for hc_283 (WIDTH=4).
`default_nettype none

module tb_hc_283;

  logic       clk;
  logic       rst_n;
  logic [3:0] DataIn1;
  logic [3:0] DataIn2;
  logic       Cout;
  logic [3:0] DataOut;

  int n_checks;
  int n_errors;

  hc_283 #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .DataIn1 (DataIn1),
    .DataIn2 (DataIn2),
    .Cout    (Cout),
    .DataOut (DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n   = 1'b0;
    DataIn1 = 4'b1010;
    DataIn2 = 4'b0101;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_0000) begin
      n_errors++;
      $display("FAIL reset_init: got %b_%b expected 0_0000", Cout, DataOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0] a_tab [7];
    logic [3:0] b_tab [7];
    logic [4:0] e_tab [7];
    a_tab = '{4'b0000, 4'b1111, 4'b0111, 4'b0100, 4'b0101, 4'b1000, 4'b1001};
    b_tab = '{4'b0110, 4'b1111, 4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1001};
    e_tab = '{5'b0_0110, 5'b1_1110, 5'b0_1001, 5'b0_1010, 5'b0_1100, 5'b0_1111, 5'b1_0010};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      DataIn1 = a_tab[k];
      DataIn2 = b_tab[k];
      for (int c = 0; c < 2; c++) begin
        @(posedge clk);
        #1;
        n_checks++;
        if ({Cout, DataOut} !== e_tab[k]) begin
          n_errors++;
          $display("FAIL directed[%0d] %b+%b cyc%0d: got %b_%b expected %b", k,
                   a_tab[k], b_tab[k], c, Cout, DataOut, e_tab[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    DataIn1 = 4'b1111;
    DataIn2 = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b1_1110) begin
      n_errors++;
      $display("FAIL midop_pre: got %b_%b expected 1_1110", Cout, DataOut);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_0000) begin
      n_errors++;
      $display("FAIL midop_async: got %b_%b expected 0_0000", Cout, DataOut);
    end
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({Cout, DataOut} !== 5'b0_0000) begin
        n_errors++;
        $display("FAIL midop_hold[%0d]: got %b_%b expected 0_0000", e, Cout, DataOut);
      end
    end
    @(negedge clk);
    DataIn1 = 4'b0011;
    DataIn2 = 4'b0001;
    rst_n   = 1'b1;
    #2;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_0000) begin
      n_errors++;
      $display("FAIL midop_release: got %b_%b expected 0_0000", Cout, DataOut);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_0100) begin
      n_errors++;
      $display("FAIL midop_first: got %b_%b expected 0_0100", Cout, DataOut);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    DataIn1 = 4'b0001;
    DataIn2 = 4'b0001;
    @(posedge clk);
    #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_0010) begin
      n_errors++;
      $display("FAIL latency_first: got %b_%b expected 0_0010", Cout, DataOut);
    end
    DataIn1 = 4'b0010;
    DataIn2 = 4'b0010;
    #2;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_0010) begin
      n_errors++;
      $display("FAIL latency_hold: got %b_%b expected 0_0010", Cout, DataOut);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_0100) begin
      n_errors++;
      $display("FAIL latency_next: got %b_%b expected 0_0100", Cout, DataOut);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v;
    int         bad;
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        DataIn1 = a[3:0];
        DataIn2 = b[3:0];
        exp_v   = 5'(a + b);
        @(posedge clk);
        #1;
        n_checks++;
        if ({Cout, DataOut} !== exp_v) begin
          n_errors++;
          if (bad < 8)
            $display("FAIL exhaustive %0d+%0d: got %b_%b expected %b", a, b, Cout, DataOut, exp_v);
          bad++;
        end
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    DataIn1 = 4'b0110;
    DataIn2 = 4'b0011;
    @(posedge clk);
    #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_1001) begin
      n_errors++;
      $display("FAIL glitch_base: got %b_%b expected 0_1001", Cout, DataOut);
    end
    DataIn1 = 4'b1111; DataIn2 = 4'b1111; #1;
    DataIn1 = 4'b0000; DataIn2 = 4'b0001; #1;
    DataIn1 = 4'b1000; DataIn2 = 4'b1000; #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_1001) begin
      n_errors++;
      $display("FAIL glitch_between: got %b_%b expected 0_1001", Cout, DataOut);
    end
    DataIn1 = 4'b0101; DataIn2 = 4'b1001; #2;
    DataIn1 = 4'b1011; DataIn2 = 4'b0111;
    n_checks++;
    if ({Cout, DataOut} !== 5'b0_1001) begin
      n_errors++;
      $display("FAIL glitch_late: got %b_%b expected 0_1001", Cout, DataOut);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({Cout, DataOut} !== 5'b1_0010) begin
      n_errors++;
      $display("FAIL glitch_edge: got %b_%b expected 1_0010", Cout, DataOut);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_directed();
    test_reset_midop();
    test_latency();
    test_back_to_back();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hc_283.md
HC_283 -- requirements
Module: hc_283

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width in bits; only WIDTH=4 is required to be verified.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; clears all state immediately on assertion.
REQ-004 DataIn1  input  WIDTH  first unsigned operand (A).
REQ-005 DataIn2  input  WIDTH  second unsigned operand (B).
REQ-006 Cout  output  1  registered carry-out of A+B.
REQ-007 DataOut  output  WIDTH  registered sum A+B modulo 2^WIDTH.
REQ-008 The module shall have no carry-in port; the LSB carry-in shall be constant 0.

Function
REQ-009 The module shall compute unsigned {carry, sum} = DataIn1 + DataIn2 as a (WIDTH+1)-bit result with no truncation before the carry split.
REQ-010 The adder core shall use per-bit generate (A&B) and propagate (A^B) terms with full carry-lookahead across all 4 bits, in the style of a 74x283 fast-carry adder; it shall not be a plain ripple chain.
REQ-011 The sum bit i shall be propagate_i XOR carry_i, and Cout shall be carry_WIDTH.
REQ-012 DataIn1 and DataIn2 shall be sampled on each rising clk edge while rst_n=1.
REQ-013 DataOut and Cout shall be registered with latency of exactly 1 cycle: the sum of the operands sampled at edge N shall appear after edge N and hold until edge N+1.
REQ-014 The module shall accept a new operand pair on every cycle and shall have no handshake and no stall.
REQ-015 Operand changes between clock edges shall not affect the outputs until the next rising edge.
REQ-016 Overflow case: 1111+1111 shall give DataOut=1110 and Cout=1, and the result shall wrap with no saturation.
REQ-017 Zero case: 0000+0000 shall give DataOut=0000 and Cout=0.
REQ-018 Carry-out shall be 1 exactly when the true sum is at least 2^WIDTH.
REQ-019 Internal state shall be only the WIDTH+1 output flip-flops, with no other state.

Reset
REQ-020 When rst_n is asserted low, DataOut shall go to 0 and Cout shall go to 0 immediately, without waiting for a clock edge.
REQ-021 While rst_n=0, the outputs shall stay 0 regardless of clk or the inputs.
REQ-022 After rst_n is released, the first rising edge shall load the sum of the operands present at that edge.
REQ-023 If reset is asserted in the middle of operation, the in-flight result shall be discarded and shall not appear after reset.

Verification
REQ-024 Clock period 10 ns, operand pair held 20 ns each; check outputs one edge after each change: 0000+0110 -> DataOut=0110, Cout=0; 1111+1111 -> 1110, Cout=1; 0111+0010 -> 1001, Cout=0.
REQ-025 Check: 0100+0110 -> 1010, Cout=0; 0101+0111 -> 1100, Cout=0; 1000+0111 -> 1111, Cout=0 (maximum sum without carry); 1001+1001 -> 0010, Cout=1.
REQ-026 Reset: drive 1111+1111 and run several cycles, then pull rst_n low between edges -> DataOut=0000 and Cout=0 at once; hold rst_n low for 3 edges -> outputs stay 0.
REQ-027 Latency: change operands from 0001+0001 to 0010+0010 just after an edge -> DataOut stays 0010 until the next edge, then becomes 0100.
REQ-028 Exhaustive: all 256 operand pairs applied back-to-back, one per cycle -> each registered {Cout, DataOut} equals the integer sum of the pair from the previous cycle.
REQ-029 Glitch test: toggle the inputs several times between two edges -> the outputs change only at the edge and reflect the values present at that edge.
